// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit buffer slice.
//   DATA_W           : byte width carried through the FIFO and to the transmitter
//   FRAME_TICKS_DEF  : default baud ticks per frame (start + 8 data + stop)
//   tx_state_e       : transmit sequencer states
//   max_int()        : helper used to size counters shared by two limits
package uart_pkg;

    localparam int DATA_W          = 8;
    localparam int FRAME_TICKS_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo -- circular byte FIFO with registered status flags.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   wr_en, wr_data   : push request; dropped (and flagged) while full
//   rd_en, rd_data   : pop request; rd_data always shows the current head
//   full, empty      : registered status, updated the cycle after an event
//   count            : registered number of stored bytes
//   overflow         : one-cycle pulse after a dropped write
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // A write is judged against the registered full flag, so a pop in the
    // same cycle never rescues a write that arrives while full.
    assign wr_acc_s = wr_en & ~full_r;
    assign rd_acc_s = rd_en & ~empty_r;

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and status flags; DEPTH is a power of two so the
    // pointers wrap DEPTH-1 -> 0 by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CW'(DEPTH));
            empty_r    <= (count_next_s == CW'(0));
            overflow_r <= wr_en & full_r;
        end
    end

    // Byte storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer -- queues bytes and feeds them one frame at a time to a
// UART transmitter, aligning each frame to the baud tick.
//   clk, rst         : system clock, asynchronous active-low reset
//   wr_en, wr_data   : byte push, one per cycle
//   tx_en            : one-cycle baud tick (clock enable only)
//   tx_data, tx_enb  : byte and frame enable towards the transmitter
//   full, empty,
//   count, overflow  : FIFO status
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int GAP_TICKS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     tx_en,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_enb,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int TW = $clog2(max_int(FRAME_TICKS, GAP_TICKS) + 1);
    // The counter holds "ticks seen so far minus one", so the last tick of a
    // phase is recognised when it equals the phase length minus one.
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

    tx_state_e         state_r;
    tx_state_e         state_next_s;
    logic [TW-1:0]     tick_cnt_r;
    logic [TW-1:0]     tick_next_s;
    logic [DATA_W-1:0] tx_data_r;
    logic [DATA_W-1:0] tx_data_next_s;
    logic              tx_enb_r;
    logic              tx_enb_next_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;
    logic              fifo_empty_s;

    uart_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (fifo_empty_s),
        .count    (count),
        .overflow (overflow)
    );

    // Sequencer next-state and next register values.
    always_comb begin
        state_next_s   = state_r;
        tick_next_s    = tick_cnt_r;
        tx_data_next_s = tx_data_r;
        tx_enb_next_s  = tx_enb_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Baud ticks are ignored here; only a queued byte moves on.
                tx_enb_next_s = 1'b0;
                tick_next_s   = '0;
                if (!fifo_empty_s) begin
                    pop_s          = 1'b1;
                    tx_data_next_s = head_s;
                    state_next_s   = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Frame starts on a tick so the first bit has full width.
                if (tx_en) begin
                    tick_next_s   = '0;
                    tx_enb_next_s = 1'b1;
                    state_next_s  = ST_SEND;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (tx_en) begin
                    if (tick_cnt_r == FRAME_LAST) begin
                        tick_next_s   = '0;
                        tx_enb_next_s = 1'b0;
                        state_next_s  = ST_GAP;
                    end else begin
                        tick_next_s = tick_cnt_r + TW'(1);
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (tx_en) begin
                    if (tick_cnt_r == GAP_LAST) begin
                        tick_next_s  = '0;
                        state_next_s = ST_IDLE;
                    end else begin
                        tick_next_s = tick_cnt_r + TW'(1);
                    end
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                tick_next_s   = '0;
                tx_enb_next_s = 1'b0;
                state_next_s  = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tick counter and registered transmitter-facing outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= '0;
            tx_data_r  <= 8'h00;
            tx_enb_r   <= 1'b0;
        end else begin
            tick_cnt_r <= tick_next_s;
            tx_data_r  <= tx_data_next_s;
            tx_enb_r   <= tx_enb_next_s;
        end
    end

    assign tx_data = tx_data_r;
    assign tx_enb  = tx_enb_r;
    assign empty   = fifo_empty_s;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer -- directed self-checking bench for uart_tx_buffer.
// Bytes expected on the line are queued when written and compared when the
// frame enable rises; frame length and inter-frame gap are measured in ticks.
module tb_uart_tx_buffer;

    localparam int DEPTH       = 8;
    localparam int FRAME_TICKS = 10;
    localparam int GAP_TICKS   = 1;
    localparam int TICK_DIV    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_enb;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    int         tick_total = 0;

    logic       tick_run;
    logic       man_tick;
    int         phase;
    logic       prev_enb;
    int         rise_ticks;
    int         fall_ticks;
    int         last_gap;
    int         frames_started;
    int         frames_done;
    logic [7:0] cur_byte;
    logic       stable_ok;
    logic [7:0] ov_b [10];

    uart_tx_buffer #(
        .DEPTH       (DEPTH),
        .FRAME_TICKS (FRAME_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_enb   (tx_enb),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Number of baud ticks consumed by the DUT so far.
    always @(posedge clk) begin
        if (tx_en) tick_total <= tick_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame monitor, run once per cycle at the falling edge.
    task automatic mon();
        if (tx_enb === 1'b1 && prev_enb === 1'b0) begin
            frames_started++;
            last_gap   = tick_total - fall_ticks;
            rise_ticks = tick_total;
            stable_ok  = 1'b1;
            cur_byte   = tx_data;
            if (exp_q.size() == 0) check("unexpected_frame", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else check("frame_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end else if (tx_enb === 1'b1 && prev_enb === 1'b1) begin
            if (tx_data !== cur_byte) stable_ok = 1'b0;
        end else if (tx_enb === 1'b0 && prev_enb === 1'b1) begin
            frames_done++;
            check("frame_ticks", tick_total - rise_ticks, FRAME_TICKS);
            check("tx_data_stable", {31'd0, stable_ok}, 32'd1);
            fall_ticks = tick_total;
        end
        prev_enb = tx_enb;
    endtask

    // Advance one cycle: observe outputs, then set the tick for the next edge.
    task automatic cycle();
        @(negedge clk);
        mon();
        if (tick_run) phase = (phase == TICK_DIV - 1) ? 0 : phase + 1;
        else phase = 0;
        tx_en = (tick_run && phase == 0) || man_tick;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic write_byte(input logic [7:0] b, input bit ok);
        wr_en   = 1'b1;
        wr_data = b;
        if (ok) exp_q.push_back(b);
        cycle();
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        int k;
        target = frames_done + n;
        k = 0;
        while (frames_done < target && k < budget) begin
            cycle();
            k++;
        end
        if (frames_done < target) check("timeout_frames", frames_done, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int k;
        int start_done;
        int remaining;

        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_en = 1'b0;
        tick_run = 1'b0; man_tick = 1'b0; phase = 0; prev_enb = 1'b0;
        rise_ticks = 0; fall_ticks = 0; last_gap = 0;
        frames_started = 0; frames_done = 0; cur_byte = 8'h00; stable_ok = 1'b1;
        ov_b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_enb", {31'd0, tx_enb}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Single byte.
        rst = 1'b1;
        tick_run = 1'b1;
        write_byte(8'h67, 1'b1);
        wait_frames(1, 200);
        check("single_empty", {31'd0, empty}, 32'd1);
        check("single_count", {28'd0, count}, 32'd0);

        // Three bytes back to back.
        write_byte(8'h67, 1'b1);
        write_byte(8'hF1, 1'b1);
        write_byte(8'hA5, 1'b1);
        wait_frames(1, 200);
        wait_frames(1, 200);
        check("gap_2", last_gap, GAP_TICKS + 1);
        wait_frames(1, 200);
        check("gap_3", last_gap, GAP_TICKS + 1);

        // Fill with ticks stopped, then overflow.
        idle(3 * TICK_DIV + 4);
        tick_run = 1'b0;
        idle(2);
        for (int i = 0; i < 9; i++) write_byte(ov_b[i], 1'b1);
        idle(2);
        check("fill_count", {28'd0, count}, 32'd8);
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_empty", {31'd0, empty}, 32'd0);
        check("fill_tx_data", {24'd0, tx_data}, {24'd0, ov_b[0]});
        check("fill_tx_enb", {31'd0, tx_enb}, 32'd0);
        write_byte(ov_b[9], 1'b0);
        check("ovf_pulse", {31'd0, overflow}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        cycle();
        check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
        check("ovf_count_hold", {28'd0, count}, 32'd8);

        // Send the loaded byte, then hold in the gap and write on the pop cycle.
        tick_run = 1'b1;
        wait_frames(1, 200);
        tick_run = 1'b0;
        idle(3);
        check("full_before_pop", {31'd0, full}, 32'd1);
        man_tick = 1'b1;
        cycle();
        man_tick = 1'b0;
        cycle();
        write_byte(8'hEE, 1'b0);
        check("pop_ovf", {31'd0, overflow}, 32'd1);
        check("pop_count", {28'd0, count}, 32'd7);
        check("pop_full", {31'd0, full}, 32'd0);
        check("pop_tx_data", {24'd0, tx_data}, {24'd0, ov_b[1]});
        tick_run = 1'b1;
        wait_frames(8, 8 * 80);
        check("drain_empty", {31'd0, empty}, 32'd1);

        // Reset in the middle of a frame.
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        snap = frames_started;
        k = 0;
        while (frames_started == snap && k < 200) begin cycle(); k++; end
        if (frames_started == snap) check("timeout_rise", frames_started, snap + 1);
        k = 0;
        while ((tick_total - rise_ticks) < 5 && k < 200) begin cycle(); k++; end
        check("mid_frame_enb", {31'd0, tx_enb}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_tx_enb", {31'd0, tx_enb}, 32'd0);
        check("abort_count", {28'd0, count}, 32'd0);
        check("abort_empty", {31'd0, empty}, 32'd1);
        check("abort_full", {31'd0, full}, 32'd0);
        exp_q.delete();
        prev_enb = 1'b0;
        cycle();
        rst = 1'b1;
        write_byte(8'h3C, 1'b1);
        wait_frames(1, 200);
        check("after_rst_empty", {31'd0, empty}, 32'd1);
        snap = frames_started;
        idle(60);
        check("no_stale_frame", frames_started, snap);

        // Twelve bytes trickled in while draining; pointers wrap.
        start_done = frames_done;
        for (int i = 0; i < 12; i++) begin
            write_byte(8'(i * 37 + 9), 1'b1);
            idle(29);
        end
        remaining = start_done + 12 - frames_done;
        if (remaining > 0) wait_frames(remaining, remaining * 80 + 100);
        check("wrap_queue_left", exp_q.size(), 0);
        check("wrap_empty", {31'd0, empty}, 32'd1);
        check("wrap_count", {28'd0, count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
